// File: rtl/mcycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, functs,
// state and instruction-class enums, ALU codes and datapath select values.
package mcycle_ctrl_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned STATE_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_SLL     = 6'h00;
    localparam logic [OP_W-1:0] FN_SRL     = 6'h02;
    localparam logic [OP_W-1:0] FN_JR      = 6'h08;
    localparam logic [OP_W-1:0] FN_SYSCALL = 6'h0C;
    localparam logic [OP_W-1:0] FN_ADD     = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB     = 6'h22;
    localparam logic [OP_W-1:0] FN_AND     = 6'h24;
    localparam logic [OP_W-1:0] FN_OR      = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT     = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b1001;

    localparam logic [SEL_W-1:0] PC_PC4    = 2'd0;
    localparam logic [SEL_W-1:0] PC_BRANCH = 2'd1;
    localparam logic [SEL_W-1:0] PC_JUMP   = 2'd2;
    localparam logic [SEL_W-1:0] PC_REG    = 2'd3;

    localparam logic [SEL_W-1:0] DST_RT  = 2'd0;
    localparam logic [SEL_W-1:0] DST_RD  = 2'd1;
    localparam logic [SEL_W-1:0] DST_R31 = 2'd2;

    localparam logic [SEL_W-1:0] WB_ALU  = 2'd0;
    localparam logic [SEL_W-1:0] WB_MEM  = 2'd1;
    localparam logic [SEL_W-1:0] WB_LINK = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_RALU, CLS_IALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE,
        CLS_J, CLS_JAL, CLS_JR, CLS_SYSCALL, CLS_ILLEGAL
    } instr_cls_t;

    typedef struct packed {
        instr_cls_t       cls;
        logic [ALU_W-1:0] alu_ctrl;
        logic             alu_src_b;
        logic             ext_sign;
        logic             illegal;
    } dec_t;

endpackage

// File: rtl/mcycle_decode.sv
// Combinational op/funct decoder: instruction class plus the EXEC-stage
// ALU controls (operation, operand-B select, immediate extension).
module mcycle_decode
    import mcycle_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    input  logic [OP_W-1:0] i_funct,
    output dec_t            o_dec
);

    always_comb begin
        o_dec.cls       = CLS_ILLEGAL;
        o_dec.alu_ctrl  = ALU_ADD;
        o_dec.alu_src_b = 1'b0;
        o_dec.ext_sign  = 1'b1;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:     begin o_dec.cls = CLS_RALU; o_dec.alu_ctrl = ALU_ADD; end
                    FN_SUB:     begin o_dec.cls = CLS_RALU; o_dec.alu_ctrl = ALU_SUB; end
                    FN_AND:     begin o_dec.cls = CLS_RALU; o_dec.alu_ctrl = ALU_AND; end
                    FN_OR:      begin o_dec.cls = CLS_RALU; o_dec.alu_ctrl = ALU_OR;  end
                    FN_SLT:     begin o_dec.cls = CLS_RALU; o_dec.alu_ctrl = ALU_SLT; end
                    FN_SLL:     begin o_dec.cls = CLS_RALU; o_dec.alu_ctrl = ALU_SLL; end
                    FN_SRL:     begin o_dec.cls = CLS_RALU; o_dec.alu_ctrl = ALU_SRL; end
                    FN_JR:      o_dec.cls = CLS_JR;
                    FN_SYSCALL: o_dec.cls = CLS_SYSCALL;
                    default:    ;
                endcase
            end
            OP_LW:   begin o_dec.cls = CLS_LW;   o_dec.alu_src_b = 1'b1; end
            OP_SW:   begin o_dec.cls = CLS_SW;   o_dec.alu_src_b = 1'b1; end
            OP_ADDI: begin o_dec.cls = CLS_IALU; o_dec.alu_src_b = 1'b1; end
            // Logical immediates are zero-extended.
            OP_ANDI: begin
                o_dec.cls       = CLS_IALU;
                o_dec.alu_ctrl  = ALU_AND;
                o_dec.alu_src_b = 1'b1;
                o_dec.ext_sign  = 1'b0;
            end
            OP_ORI: begin
                o_dec.cls       = CLS_IALU;
                o_dec.alu_ctrl  = ALU_OR;
                o_dec.alu_src_b = 1'b1;
                o_dec.ext_sign  = 1'b0;
            end
            OP_BEQ:  begin o_dec.cls = CLS_BEQ; o_dec.alu_ctrl = ALU_SUB; end
            OP_BNE:  begin o_dec.cls = CLS_BNE; o_dec.alu_ctrl = ALU_SUB; end
            OP_J:    o_dec.cls = CLS_J;
            OP_JAL:  o_dec.cls = CLS_JAL;
            default: ;
        endcase
        o_dec.illegal = (o_dec.cls == CLS_ILLEGAL);
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb, guards
// memory handshakes with a timeout and counts retired instructions.
module mcycle_ctrl
    import mcycle_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned MEM_TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             op,
    input  logic [5:0]             funct,
    input  logic                   alu_zero,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    output logic                   imem_req,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic                   ir_we,
    output logic                   pc_we,
    output logic [1:0]             pc_src,
    output logic                   reg_we,
    output logic [1:0]             reg_dst,
    output logic [1:0]             wb_sel,
    output logic                   alu_src_b,
    output logic                   ext_sign,
    output logic [3:0]             alu_ctrl,
    output logic                   illegal,
    output logic                   bus_error,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic [2:0]             state
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [TW-1:0]          r_tmo;
    logic                   r_bus_error;
    logic [COUNT_WIDTH-1:0] r_retired;
    logic                   w_wait;
    logic                   w_timeout;
    logic                   w_retire;
    logic                   w_tmo_last;
    dec_t                   w_dec;

    mcycle_decode u_decode (
        .i_op    (op),
        .i_funct (funct),
        .o_dec   (w_dec)
    );

    // Cycle in which a further missing ready exhausts the wait budget.
    assign w_tmo_last    = (r_tmo == TW'(MEM_TIMEOUT - 1));
    assign state         = r_state;
    assign bus_error     = r_bus_error;
    assign retired_count = r_retired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_tmo       <= '0;
            r_bus_error <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_tmo <= '0;
            end else if (w_wait) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + COUNT_WIDTH'(1);
            end
        end
    end

    // Next state and datapath controls; everything stays idle while rst is high.
    always_comb begin
        w_state_next = r_state;
        w_wait       = 1'b0;
        w_timeout    = 1'b0;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PC4;
        reg_we       = 1'b0;
        reg_dst      = DST_RT;
        wb_sel       = WB_ALU;
        alu_src_b    = 1'b0;
        ext_sign     = 1'b0;
        alu_ctrl     = ALU_ADD;
        illegal      = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we        = 1'b1;
                        pc_we        = 1'b1;
                        pc_src       = PC_PC4;
                        w_state_next = ST_DECODE;
                    end else if (w_tmo_last) begin
                        w_timeout    = 1'b1;
                        w_state_next = ST_HALT;
                    end else begin
                        w_wait = 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_dec.illegal) begin
                        illegal      = 1'b1;
                        w_state_next = ST_FETCH;
                    end else if (w_dec.cls == CLS_SYSCALL) begin
                        w_retire     = 1'b1;
                        w_state_next = ST_HALT;
                    end else begin
                        w_state_next = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_ctrl  = w_dec.alu_ctrl;
                    alu_src_b = w_dec.alu_src_b;
                    ext_sign  = w_dec.ext_sign;
                    case (w_dec.cls)
                        CLS_BEQ, CLS_BNE: begin
                            if ((w_dec.cls == CLS_BEQ) == alu_zero) begin
                                pc_we  = 1'b1;
                                pc_src = PC_BRANCH;
                            end
                            w_retire     = 1'b1;
                            w_state_next = ST_FETCH;
                        end
                        CLS_J: begin
                            pc_we        = 1'b1;
                            pc_src       = PC_JUMP;
                            w_retire     = 1'b1;
                            w_state_next = ST_FETCH;
                        end
                        CLS_JR: begin
                            pc_we        = 1'b1;
                            pc_src       = PC_REG;
                            w_retire     = 1'b1;
                            w_state_next = ST_FETCH;
                        end
                        // Link write happens alongside the jump, no WB visit.
                        CLS_JAL: begin
                            pc_we        = 1'b1;
                            pc_src       = PC_JUMP;
                            reg_we       = 1'b1;
                            reg_dst      = DST_R31;
                            wb_sel       = WB_LINK;
                            w_retire     = 1'b1;
                            w_state_next = ST_FETCH;
                        end
                        CLS_LW, CLS_SW: w_state_next = ST_MEM;
                        default:        w_state_next = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (w_dec.cls == CLS_SW);
                    if (dmem_ready) begin
                        if (w_dec.cls == CLS_SW) begin
                            w_retire     = 1'b1;
                            w_state_next = ST_FETCH;
                        end else begin
                            w_state_next = ST_WB;
                        end
                    end else if (w_tmo_last) begin
                        w_timeout    = 1'b1;
                        w_state_next = ST_HALT;
                    end else begin
                        w_wait = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_we       = 1'b1;
                    reg_dst      = (w_dec.cls == CLS_RALU) ? DST_RD : DST_RT;
                    wb_sel       = (w_dec.cls == CLS_LW) ? WB_MEM : WB_ALU;
                    w_retire     = 1'b1;
                    w_state_next = ST_FETCH;
                end
                ST_HALT: halted = 1'b1;
                default: w_state_next = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: instruction table with a scoreboard,
// plus hand sequences for waits, timeouts, syscall and mid-flight reset.
module tb_mcycle_ctrl;
    import mcycle_ctrl_pkg::*;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = '0, funct = '0;
    logic        alu_zero = 1'b0, imem_ready = 1'b1, dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
    logic        alu_src_b, ext_sign, illegal, bus_error, halted;
    logic [1:0]  pc_src, reg_dst, wb_sel;
    logic [3:0]  alu_ctrl;
    logic [31:0] retired_count;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ret = 0;

    typedef struct {
        int cycles; logic [3:0] alu; logic srcb; logic sext; logic pcwe; logic [1:0] pcsrc;
        logic rwe; logic [1:0] rdst; logic [1:0] wbsel; logic dwe; int dq; int ill; int ret;
        logic [11:0] trace;
    } res_t;

    typedef struct {
        string nm; logic [5:0] op; logic [5:0] fn; logic z; logic chk_alu; res_t e;
    } vec_t;

    vec_t vecs[21];
    res_t sb_q[$];

    mcycle_ctrl #(.COUNT_WIDTH(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .alu_src_b(alu_src_b), .ext_sign(ext_sign), .alu_ctrl(alu_ctrl),
        .illegal(illegal), .bus_error(bus_error), .halted(halted),
        .retired_count(retired_count), .state(state)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(int cyc, logic [3:0] alu, logic srcb, logic sext, logic pcwe,
                                logic [1:0] pcsrc, logic rwe, logic [1:0] rdst, logic [1:0] wbsel,
                                logic dwe, int dq, int ill, int ret);
        res_t r;
        r.cycles = cyc; r.alu = alu; r.srcb = srcb; r.sext = sext; r.pcwe = pcwe;
        r.pcsrc = pcsrc; r.rwe = rwe; r.rdst = rdst; r.wbsel = wbsel; r.dwe = dwe;
        r.dq = dq; r.ill = ill; r.ret = ret; r.trace = '0;
        return r;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drives one instruction from FETCH until it is back in FETCH or in HALT.
    task automatic run_instr(input logic [5:0] i_op, input logic [5:0] i_fn, input logic z,
                             input int iwait, input int dwait, output res_t o);
        int  icnt = 0;
        int  dcnt = 0;
        bit  moved = 0;
        logic [31:0] r0;
        o = mk(0, 4'd0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
        r0 = retired_count;
        op = i_op; funct = i_fn; alu_zero = z;
        for (int c = 1; c <= 60; c++) begin
            if (state == S_F) begin icnt++; imem_ready = (icnt > iwait); end
            if (state == S_M) begin dcnt++; dmem_ready = (dcnt > dwait); end
            else dmem_ready = 1'b0;
            #1;
            o.trace = {o.trace[8:0], state};
            if (state == S_E) begin
                o.alu = alu_ctrl; o.srcb = alu_src_b; o.sext = ext_sign; o.pcwe = pc_we;
                if (pc_we) o.pcsrc = pc_src;
            end
            if (reg_we) begin o.rwe = 1'b1; o.rdst = reg_dst; o.wbsel = wb_sel; end
            if (dmem_req) o.dq++;
            if (dmem_req && dmem_we) o.dwe = 1'b1;
            if (illegal) o.ill++;
            @(negedge clk);
            o.cycles = c;
            if (state != S_F) moved = 1;
            if ((moved && state == S_F) || state == S_H) break;
        end
        dmem_ready = 1'b0;
        o.ret = int'(retired_count - r0);
    endtask

    task automatic cmp(input string nm, input logic chk_alu, input res_t e, input res_t o);
        check({nm, ".cycles"}, o.cycles, e.cycles);
        if (chk_alu) check({nm, ".alu_ctrl"}, o.alu, e.alu);
        check({nm, ".alu_src_b"}, o.srcb, e.srcb);
        check({nm, ".ext_sign"}, o.sext, e.sext);
        check({nm, ".pc_we_exec"}, o.pcwe, e.pcwe);
        check({nm, ".pc_src_exec"}, o.pcsrc, e.pcsrc);
        check({nm, ".reg_we"}, o.rwe, e.rwe);
        check({nm, ".reg_dst"}, o.rdst, e.rdst);
        check({nm, ".wb_sel"}, o.wbsel, e.wbsel);
        check({nm, ".dmem_we"}, o.dwe, e.dwe);
        check({nm, ".dmem_req_cycles"}, o.dq, e.dq);
        check({nm, ".illegal_cycles"}, o.ill, e.ill);
        check({nm, ".retired_delta"}, o.ret, e.ret);
    endtask

    task automatic reset_and_check(input string nm);
        rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        check({nm, ".state"}, state, S_F);
        check({nm, ".imem_req"}, imem_req, 0);
        check({nm, ".dmem_req"}, dmem_req, 0);
        check({nm, ".pc_we"}, pc_we, 0);
        check({nm, ".ir_we"}, ir_we, 0);
        check({nm, ".reg_we"}, reg_we, 0);
        check({nm, ".halted"}, halted, 0);
        check({nm, ".bus_error"}, bus_error, 0);
        check({nm, ".retired"}, retired_count, 0);
        exp_ret = 0;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t o, e;
        vecs[0]  = '{"add",  6'h00, 6'h20, 1'b0, 1'b1, mk(4, ALU_ADD, 0, 1, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 0, 1)};
        vecs[1]  = '{"sub",  6'h00, 6'h22, 1'b0, 1'b1, mk(4, ALU_SUB, 0, 1, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 0, 1)};
        vecs[2]  = '{"and",  6'h00, 6'h24, 1'b0, 1'b1, mk(4, ALU_AND, 0, 1, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 0, 1)};
        vecs[3]  = '{"or",   6'h00, 6'h25, 1'b0, 1'b1, mk(4, ALU_OR,  0, 1, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 0, 1)};
        vecs[4]  = '{"slt",  6'h00, 6'h2A, 1'b0, 1'b1, mk(4, ALU_SLT, 0, 1, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 0, 1)};
        vecs[5]  = '{"sll",  6'h00, 6'h00, 1'b0, 1'b1, mk(4, ALU_SLL, 0, 1, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 0, 1)};
        vecs[6]  = '{"srl",  6'h00, 6'h02, 1'b0, 1'b1, mk(4, ALU_SRL, 0, 1, 0, 2'd0, 1, 2'd1, 2'd0, 0, 0, 0, 1)};
        vecs[7]  = '{"jr",   6'h00, 6'h08, 1'b0, 1'b0, mk(3, ALU_ADD, 0, 1, 1, 2'd3, 0, 2'd0, 2'd0, 0, 0, 0, 1)};
        vecs[8]  = '{"addi", 6'h08, 6'h15, 1'b0, 1'b1, mk(4, ALU_ADD, 1, 1, 0, 2'd0, 1, 2'd0, 2'd0, 0, 0, 0, 1)};
        vecs[9]  = '{"andi", 6'h0C, 6'h00, 1'b0, 1'b1, mk(4, ALU_AND, 1, 0, 0, 2'd0, 1, 2'd0, 2'd0, 0, 0, 0, 1)};
        vecs[10] = '{"ori",  6'h0D, 6'h3F, 1'b0, 1'b1, mk(4, ALU_OR,  1, 0, 0, 2'd0, 1, 2'd0, 2'd0, 0, 0, 0, 1)};
        vecs[11] = '{"lw",   6'h23, 6'h00, 1'b0, 1'b1, mk(5, ALU_ADD, 1, 1, 0, 2'd0, 1, 2'd0, 2'd1, 0, 1, 0, 1)};
        vecs[12] = '{"sw",   6'h2B, 6'h00, 1'b0, 1'b1, mk(4, ALU_ADD, 1, 1, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 0, 1)};
        vecs[13] = '{"beq_t",6'h04, 6'h00, 1'b1, 1'b1, mk(3, ALU_SUB, 0, 1, 1, 2'd1, 0, 2'd0, 2'd0, 0, 0, 0, 1)};
        vecs[14] = '{"beq_n",6'h04, 6'h00, 1'b0, 1'b1, mk(3, ALU_SUB, 0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 1)};
        vecs[15] = '{"bne_n",6'h05, 6'h00, 1'b1, 1'b1, mk(3, ALU_SUB, 0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 1)};
        vecs[16] = '{"bne_t",6'h05, 6'h00, 1'b0, 1'b1, mk(3, ALU_SUB, 0, 1, 1, 2'd1, 0, 2'd0, 2'd0, 0, 0, 0, 1)};
        vecs[17] = '{"j",    6'h02, 6'h00, 1'b0, 1'b0, mk(3, ALU_ADD, 0, 1, 1, 2'd2, 0, 2'd0, 2'd0, 0, 0, 0, 1)};
        vecs[18] = '{"jal",  6'h03, 6'h00, 1'b0, 1'b0, mk(3, ALU_ADD, 0, 1, 1, 2'd2, 1, 2'd2, 2'd2, 0, 0, 0, 1)};
        vecs[19] = '{"ill_op",6'h3F,6'h00, 1'b0, 1'b0, mk(2, ALU_ADD, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 1, 0)};
        vecs[20] = '{"ill_fn",6'h00,6'h01, 1'b0, 1'b0, mk(2, ALU_ADD, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 1, 0)};

        reset_and_check("reset0");
        #1;
        check("release.imem_req", imem_req, 1);

        // First instruction after reset: add walks F,D,E,W.
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, o);
        exp_ret += 1;
        check("add0.trace", o.trace, {S_F, S_D, S_E, S_W});
        check("add0.rd_dst", o.rdst, 1);
        check("add0.retired", retired_count, exp_ret);

        foreach (vecs[i]) begin
            sb_q.push_back(vecs[i].e);
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, 0, 0, o);
            if (sb_q.size() == 0) begin
                check({vecs[i].nm, ".scoreboard_empty"}, 1, 0);
            end else begin
                e = sb_q.pop_front();
                cmp(vecs[i].nm, vecs[i].chk_alu, e, o);
                exp_ret += e.ret;
            end
        end
        check("table.retired", retired_count, exp_ret);

        run_instr(6'h23, 6'h00, 1'b0, 0, 3, o);
        exp_ret += 1;
        check("lw_wait.cycles", o.cycles, 8);
        check("lw_wait.dmem_req_cycles", o.dq, 4);
        check("lw_wait.wb_sel", o.wbsel, 1);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 2, o);
        exp_ret += 1;
        check("sw_wait.cycles", o.cycles, 6);
        check("sw_wait.dmem_we", o.dwe, 1);
        check("sw_wait.reg_we", o.rwe, 0);

        // imem ready arriving in the last allowed cycle completes normally.
        run_instr(6'h00, 6'h22, 1'b0, 3, 0, o);
        exp_ret += 1;
        check("imem_late.cycles", o.cycles, 7);
        check("imem_late.bus_error", bus_error, 0);
        check("imem_late.retired", retired_count, exp_ret);

        // Reset while a data access is waiting for ready.
        op = 6'h23; funct = 6'h00; imem_ready = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 10 && state != S_M; c++) @(negedge clk);
        @(negedge clk);
        check("mid_mem.state", state, S_M);
        reset_and_check("rst_mem");

        run_instr(6'h00, 6'h20, 1'b0, NEVER, 0, o);
        check("imem_tmo.cycles", o.cycles, 4);
        check("imem_tmo.state", state, S_H);
        check("imem_tmo.bus_error", bus_error, 1);
        check("imem_tmo.halted", halted, 1);
        check("imem_tmo.imem_req", imem_req, 0);
        imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("halt_hold.state", state, S_H);
        check("halt_hold.pc_we", pc_we, 0);
        check("halt_hold.retired", retired_count, exp_ret);
        reset_and_check("rst_halt");

        run_instr(6'h23, 6'h00, 1'b0, 0, NEVER, o);
        check("dmem_tmo.cycles", o.cycles, 7);
        check("dmem_tmo.dmem_req_cycles", o.dq, 4);
        check("dmem_tmo.bus_error", bus_error, 1);
        check("dmem_tmo.state", state, S_H);
        reset_and_check("rst_dtmo");

        run_instr(6'h00, 6'h0C, 1'b0, 0, 0, o);
        exp_ret += 1;
        check("syscall.cycles", o.cycles, 2);
        check("syscall.halted", halted, 1);
        check("syscall.bus_error", bus_error, 0);
        check("syscall.retired", retired_count, exp_ret);
        reset_and_check("rst_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
